// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings (common with the transmitter)
// and parity-type constants.
package uart_defs;

   localparam int unsigned UART_STATE_W = 3;

   typedef enum logic [UART_STATE_W-1:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: synchronizes the raw line, keeps the per-bit edge
// counter and produces the sampled bit value plus an end-of-bit strobe.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority around the bit centre.
module uart_rx_sampler #(
   parameter int unsigned PRESCALE = 8,
   parameter int unsigned CNTWIDTH = 5
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rx_i,
   input  logic run_i,
   output logic rx_s_o,
   output logic sampled_bit_o,
   output logic bit_end_o
);

   localparam logic [CNTWIDTH-1:0] CntLast = CNTWIDTH'(PRESCALE - 1);
   localparam logic [CNTWIDTH-1:0] CntMid  = CNTWIDTH'(PRESCALE / 2);

   logic                sync1_q, sync2_q;
   logic [CNTWIDTH-1:0] edge_cnt_q, edge_cnt_d;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
      end
   end

   // Edge counter runs only while a frame is in progress and wraps every bit.
   always_comb begin
      edge_cnt_d = '0;
      if (run_i && (edge_cnt_q != CntLast)) begin
         edge_cnt_d = edge_cnt_q + CNTWIDTH'(1);
      end
   end

   // Edge counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         edge_cnt_q <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CNTWIDTH-1:0] CntEarly = CNTWIDTH'(PRESCALE / 2 - 1);
   localparam logic [CNTWIDTH-1:0] CntLate  = CNTWIDTH'(PRESCALE / 2 + 1);

   logic [2:0] smp_q, smp_d;
   logic       late_smp;

   // Capture the three samples around the bit centre.
   always_comb begin
      smp_d = smp_q;
      if (run_i) begin
         if (edge_cnt_q == CntEarly) smp_d[0] = sync2_q;
         if (edge_cnt_q == CntMid)   smp_d[1] = sync2_q;
         if (edge_cnt_q == CntLate)  smp_d[2] = sync2_q;
      end
   end

   // Sample register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         smp_q <= 3'b111;
      end else begin
         smp_q <= smp_d;
      end
   end

   // With PRESCALE=4 the late sample coincides with bit end, so use it live.
   always_comb begin
      late_smp      = (edge_cnt_q == CntLate) ? sync2_q : smp_q[2];
      sampled_bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & late_smp) | (smp_q[1] & late_smp);
   end
`else
   logic sample_q, sample_d;

   // Single sample at the bit centre.
   always_comb begin
      sample_d = sample_q;
      if (run_i && (edge_cnt_q == CntMid)) begin
         sample_d = sync2_q;
      end
   end

   // Sample register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sample_q <= 1'b1;
      end else begin
         sample_q <= sample_d;
      end
   end

   assign sampled_bit_o = sample_q;
`endif

   assign rx_s_o    = sync2_q;
   assign bit_end_o = run_i && (edge_cnt_q == CntLast);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATAWIDTH data bits LSB-first, optional parity, one
// stop bit. Reports each frame with exactly one registered pulse:
// DATA_VALID, PAR_ERR or STP_ERR.
// Build option UART_RX_MAJORITY_EN selects majority sampling in the sampler.
module uart_rx
   import uart_defs::*;
#(
   parameter int unsigned DATAWIDTH  = 8,
   parameter int unsigned STATEWIDTH = 3,
   parameter int unsigned PRESCALE   = 8,
   parameter int unsigned CNTWIDTH   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RX_IN,
   input  logic                 PAR_EN,
   input  logic                 PAR_TYP,
   output logic [DATAWIDTH-1:0] P_DATA,
   output logic                 DATA_VALID,
   output logic                 PAR_ERR,
   output logic                 STP_ERR,
   output logic                 Busy
);

   if (PRESCALE < 4 || PRESCALE > 32) begin : g_bad_prescale
      $error("uart_rx: PRESCALE must be within 4..32");
   end
   if ((PRESCALE - 1) > (2 ** CNTWIDTH - 1) || DATAWIDTH > (2 ** CNTWIDTH - 1)) begin : g_bad_cnt
      $error("uart_rx: CNTWIDTH too small for PRESCALE-1 or DATAWIDTH");
   end
   if (STATEWIDTH != UART_STATE_W) begin : g_bad_state
      $error("uart_rx: STATEWIDTH must match the shared state encoding width");
   end

   localparam logic [CNTWIDTH-1:0] DataLast = CNTWIDTH'(DATAWIDTH - 1);

   uart_state_e          state_q, state_d;
   logic [CNTWIDTH-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATAWIDTH-1:0] shift_q, shift_d;
   logic [DATAWIDTH-1:0] p_data_q, p_data_d;
   logic                 par_en_q, par_en_d;
   logic                 par_typ_q, par_typ_d;
   logic                 par_bad_q, par_bad_d;
   logic                 armed_q, armed_d;
   logic                 dv_q, dv_d;
   logic                 pe_q, pe_d;
   logic                 se_q, se_d;
   logic                 busy_q, busy_d;
   logic                 start_frame;

   logic run, rx_s, sampled_bit, bit_end;

   assign run = (state_q != IDLE);

   uart_rx_sampler #(
      .PRESCALE (PRESCALE),
      .CNTWIDTH (CNTWIDTH)
   ) u_sampler (
      .clk_i         (clk),
      .rst_ni        (rst),
      .rx_i          (RX_IN),
      .run_i         (run),
      .rx_s_o        (rx_s),
      .sampled_bit_o (sampled_bit),
      .bit_end_o     (bit_end)
   );

   // Frame FSM next state, datapath updates and outcome pulses.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      p_data_d    = p_data_q;
      par_en_d    = par_en_q;
      par_typ_d   = par_typ_q;
      par_bad_d   = par_bad_q;
      armed_d     = armed_q;
      dv_d        = 1'b0;
      pe_d        = 1'b0;
      se_d        = 1'b0;
      start_frame = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Stay disarmed after a stop error until the line returns high.
            if (rx_s) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               start_frame = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = sampled_bit ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               // Right shift: first received bit ends up in bit 0.
               shift_d = {sampled_bit, shift_q[DATAWIDTH-1:1]};
               if (bit_cnt_q == DataLast) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNTWIDTH'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               par_bad_d = sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
               state_d   = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               if (!sampled_bit) begin
                  se_d    = 1'b1;
                  armed_d = 1'b0;
               end else begin
                  if (par_bad_q) begin
                     pe_d = 1'b1;
                  end else begin
                     dv_d     = 1'b1;
                     p_data_d = shift_q;
                  end
                  // Back-to-back frame: start edge already visible on the last stop cycle.
                  if (!rx_s) begin
                     start_frame = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_frame) begin
         state_d   = START;
         bit_cnt_d = '0;
         par_en_d  = PAR_EN;
         par_typ_d = PAR_TYP;
         par_bad_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         p_data_q  <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
         par_bad_q <= 1'b0;
         armed_q   <= 1'b1;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         p_data_q  <= p_data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         par_bad_q <= par_bad_d;
         armed_q   <= armed_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
         busy_q    <= busy_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign DATA_VALID = dv_q;
   assign PAR_ERR    = pe_q;
   assign STP_ERR    = se_q;
   assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx (PRESCALE=8): table of single frames plus hand-written
// sequences for break, start glitch, mid-frame reset and back-to-back frames.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       DATA_VALID, PAR_ERR, STP_ERR, Busy;

   uart_rx dut (
      .clk        (clk),
      .rst        (rst),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR),
      .Busy       (Busy)
   );

   always #5 clk = ~clk;

`ifdef UART_RX_MAJORITY_EN
   localparam bit GlitchEn = 1'b1;
`else
   localparam bit GlitchEn = 1'b0;
`endif

   int n_chk = 0;
   int n_err = 0;

   // Edge number: becomes N at the N-th rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   int         dv_n = 0, pe_n = 0, se_n = 0, busy_n = 0;
   int         dv_last = 0, dv_prev = 0, pe_last = 0, se_last = 0;
   logic [7:0] pd_last = '0, pd_prev = '0;
   always @(negedge clk) begin
      if (DATA_VALID === 1'b1) begin
         dv_n    <= dv_n + 1;
         dv_prev <= dv_last;
         dv_last <= cyc;
         pd_prev <= pd_last;
         pd_last <= P_DATA;
      end
      if (PAR_ERR === 1'b1) begin
         pe_n    <= pe_n + 1;
         pe_last <= cyc;
      end
      if (STP_ERR === 1'b1) begin
         se_n    <= se_n + 1;
         se_last <= cyc;
      end
      if (Busy === 1'b1) busy_n <= busy_n + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame (or its first nbits bits); t0 is the edge that sees the start bit.
   task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_bit,
                             input logic stop_bit, input bit glitch, input int nbits,
                             output int t0, output int busy_bad);
      logic [10:0] bits;
      int          n;
      bits      = '1;
      bits[0]   = 1'b0;
      bits[8:1] = data;
      if (par_en) begin
         bits[9]  = par_bit;
         bits[10] = stop_bit;
         n        = 11;
      end else begin
         bits[9] = stop_bit;
         n       = 10;
      end
      if (nbits < n) n = nbits;
      t0       = cyc + 1;
      busy_bad = 0;
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < 8; j++) begin
            if (k >= 1 && j == 0 && Busy !== 1'b1) busy_bad++;
            RX_IN = (glitch && j == 5) ? ~bits[k] : bits[k];
            tick(1);
         end
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       par_typ;
      logic       par_bit;
      logic       stop_bit;
      int         exp_dv;
      int         exp_pe;
      int         exp_se;
      logic [7:0] exp_pdata;
      int         exp_lat;
   } vec_t;

   vec_t       vecs[8];
   int         t0, t1, bb, dv0, pe0, se0, b0, lat;
   logic [7:0] pd_before;

   initial begin
      vecs[0] = '{8'hCC, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hCC, 90}; // even parity ok
      vecs[1] = '{8'hF5, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 0, 8'hCC, 90}; // odd parity wrong
      vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h5A, 82}; // no parity
      vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 0, 8'h00, 90}; // odd parity ok
      vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'h00, 90}; // even parity wrong
      vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h00, 82}; // stop error
      vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h00, 90}; // parity ok, stop bad
      vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h00, 90}; // both bad: stop wins

      // Reset state.
      tick(3);
      chk("reset P_DATA", int'(P_DATA), 0);
      chk("reset DATA_VALID", int'(DATA_VALID), 0);
      chk("reset PAR_ERR", int'(PAR_ERR), 0);
      chk("reset STP_ERR", int'(STP_ERR), 0);
      chk("reset Busy", int'(Busy), 0);
      rst = 1'b1;
      tick(10);

      // Table-driven single frames.
      for (int i = 0; i < 8; i++) begin
         PAR_EN  = vecs[i].par_en;
         PAR_TYP = vecs[i].par_typ;
         dv0 = dv_n; pe0 = pe_n; se0 = se_n;
         send_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_bit, vecs[i].stop_bit, 1'b0, 99,
                    t0, bb);
         RX_IN = 1'b1;
         tick(20);
         chk($sformatf("vec%0d DATA_VALID count", i), dv_n - dv0, vecs[i].exp_dv);
         chk($sformatf("vec%0d PAR_ERR count", i), pe_n - pe0, vecs[i].exp_pe);
         chk($sformatf("vec%0d STP_ERR count", i), se_n - se0, vecs[i].exp_se);
         chk($sformatf("vec%0d P_DATA", i), int'(P_DATA), int'(vecs[i].exp_pdata));
         chk($sformatf("vec%0d Busy during frame", i), bb, 0);
         if (vecs[i].exp_dv != 0) lat = dv_last - t0;
         else if (vecs[i].exp_pe != 0) lat = pe_last - t0;
         else lat = se_last - t0;
         chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      end

      // Stop error followed by a 200-clock break, then a good frame.
      PAR_EN = 1'b0;
      se0 = se_n; dv0 = dv_n;
      send_frame(8'h85, 1'b0, 1'b0, 1'b0, 1'b0, 99, t0, bb);
      tick(5);
      b0 = busy_n;
      tick(195);
      chk("break STP_ERR count", se_n - se0, 1);
      chk("break STP_ERR latency", se_last - t0, 82);
      chk("break Busy cycles", busy_n - b0, 0);
      chk("break DATA_VALID count", dv_n - dv0, 0);
      RX_IN = 1'b1;
      tick(10);
      send_frame(8'h85, 1'b0, 1'b0, 1'b1, 1'b0, 99, t0, bb);
      RX_IN = 1'b1;
      tick(20);
      chk("after break DATA_VALID count", dv_n - dv0, 1);
      chk("after break P_DATA", int'(P_DATA), 8'h85);

      // Start glitch: line low for two clocks only.
      dv0 = dv_n; pe0 = pe_n; se0 = se_n;
      pd_before = P_DATA;
      t0 = cyc + 1;
      RX_IN = 1'b0;
      tick(2);
      RX_IN = 1'b1;
      tick(3);
      chk("glitch Busy started", int'(Busy), 1);
      tick(6);
      chk("glitch Busy low by clock 11", int'(Busy), 0);
      tick(30);
      chk("glitch pulse count", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);
      chk("glitch P_DATA held", int'(P_DATA), int'(pd_before));

      // Reset asserted during data bit 3.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 4, t0, bb);
      RX_IN = 1'b0;
      tick(4);
      chk("pre-reset Busy", int'(Busy), 1);
      rst = 1'b0;
      #1;
      chk("mid-reset P_DATA", int'(P_DATA), 0);
      chk("mid-reset Busy", int'(Busy), 0);
      chk("mid-reset pulses", int'(DATA_VALID) + int'(PAR_ERR) + int'(STP_ERR), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      RX_IN = 1'b1;
      tick(10);
      dv0 = dv_n;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 99, t0, bb);
      RX_IN = 1'b1;
      tick(20);
      chk("post-reset DATA_VALID count", dv_n - dv0, 1);
      chk("post-reset P_DATA", int'(P_DATA), 8'hA5);
      chk("post-reset latency", dv_last - t0, 82);

      // Back-to-back frames with minimum stop bit.
      dv0 = dv_n;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, GlitchEn, 99, t0, bb);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, GlitchEn, 99, t1, bb);
      RX_IN = 1'b1;
      tick(20);
      chk("b2b DATA_VALID count", dv_n - dv0, 2);
      chk("b2b pulse spacing", dv_last - dv_prev, 80);
      chk("b2b first latency", dv_prev - t0, 82);
      chk("b2b first P_DATA", int'(pd_prev), 8'h3C);
      chk("b2b second P_DATA", int'(pd_last), 8'hC3);
      chk("b2b final P_DATA", int'(P_DATA), 8'hC3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's UART transmitter.
- Same frame format: start(0), DATAWIDTH data bits LSB-first, optional parity, one stop(1).
- Oversamples serial line RX_IN at PRESCALE clocks per bit, recovers the byte and checks parity/stop.
- Presents P_DATA with a one-cycle DATA_VALID pulse to the host side.

Parameters:
- DATAWIDTH, 8, data bits per frame.
- STATEWIDTH, 3, FSM state register width.
- PRESCALE, 8, clocks per bit. Legal range 4..32; elaboration error otherwise.
- CNTWIDTH, 5, width of edge/bit counters; must hold max(PRESCALE-1, DATAWIDTH).

Ports:
- clk  input  1  system clock, PRESCALE x baud rate.
- rst  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idle high; asynchronous to clk.
- PAR_EN  input  1  1 = frame carries a parity bit; sampled at start detection.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled at start detection.
- P_DATA  output  DATAWIDTH  last good received word.
- DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
- PAR_ERR  output  1  one-cycle pulse: parity mismatch.
- STP_ERR  output  1  one-cycle pulse: stop bit sampled 0.
- Busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (rst=0, async): FSM→IDLE, counters 0, P_DATA=0, DATA_VALID=PAR_ERR=STP_ERR=Busy=0, armed=1. Reset mid-frame discards the partial frame silently.
- RX_IN passes through a 2-flop synchronizer; rx_s is its output. All timing below is relative to rx_s.
- edge_cnt counts 0..PRESCALE-1 within each bit. bit_cnt counts data bits 0..DATAWIDTH-1.
- Bit value: sample at edge_cnt=PRESCALE/2, integer division.
- IDLE:
  - If armed and rx_s=0: go to START with edge_cnt=0; latch PAR_EN/PAR_TYP.
  - Armed is cleared after STP_ERR and set again when rx_s=1 is seen in IDLE. This handles a break condition without repeated errors.
- START: at edge_cnt=PRESCALE-1, sampled bit=0 → DATA, else IDLE (glitch). A glitch produces no output pulses.
- DATA: at each edge_cnt=PRESCALE-1, shift the sampled bit into shift register bit[bit_cnt] (LSB-first). After bit DATAWIDTH-1, go to PARITY if latched PAR_EN, else STOP.
- PARITY: expected = ^data XOR PAR_TYP. Mismatch sets an internal par_bad flag. At edge_cnt=PRESCALE-1 → STOP.
- STOP: at edge_cnt=PRESCALE-1 → IDLE. On the next cycle exactly one of the following holds:
  - stop bit=0: STP_ERR=1, P_DATA unchanged.
  - stop ok and par_bad: PAR_ERR=1, P_DATA unchanged.
  - otherwise: DATA_VALID=1 and P_DATA = shift register.
- Stop error has priority over parity error; only one pulse per frame.
- Latency: the outcome pulse appears exactly (1+DATAWIDTH+PAR_EN+1)*PRESCALE+2 clocks after the first clk edge that sees raw RX_IN=0. With defaults: 82 clocks (no parity), 90 clocks (with parity).
- Back-to-back frames: a new start edge is accepted on the first IDLE cycle. A stop bit of exactly PRESCALE clocks is sufficient.
- P_DATA holds its value between frames. All outputs are registered.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: bit value = 2-of-3 majority of samples at edge_cnt PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1. A single-cycle line glitch at the centre is rejected.
- Undefined: single sample at PRESCALE/2.
- Frame timing and outcome latency are identical in both builds.

Decomposition:
- Shared package/header uart_defs holds:
  - state encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (STATEWIDTH=3), common with the transmitter;
  - parity constants PAR_EVEN=0, PAR_ODD=1.
- Sub-module uart_rx_sampler: owns the synchronizer, edge_cnt and the sampling/majority logic. It outputs sampled_bit and bit_end strobes to the FSM/datapath in uart_rx.

Test Plan (PRESCALE=8, bit = 8 clocks):
- Reception with even parity: frame 8'b11001100, PAR_EN=1, PAR_TYP=0, parity bit 0 → DATA_VALID at clock 90, P_DATA=8'hCC, no errors; Busy high throughout the frame.
- Parity error: frame 8'b11110101, PAR_EN=1, PAR_TYP=1, wrong parity bit 0 → PAR_ERR pulse at clock 90, DATA_VALID=0, P_DATA stays 8'hCC.
- Stop error and break: frame 8'b10000101, PAR_EN=0, stop=0, line then held low 200 clocks → single STP_ERR at clock 82 and no further Busy. After the line returns high, a good 8'h85 frame gives DATA_VALID and P_DATA=8'h85.
- Start glitch: RX_IN low for 2 clocks only → Busy returns low by clock 11, no pulses, P_DATA unchanged.
- Reset mid-frame: rst=0 during data bit 3 → all outputs 0 immediately. The next full frame 8'hA5 is received correctly.
- Back-to-back: 8'h3C then 8'hC3 with 8-clock stop bits, no gap → two DATA_VALID pulses 80 clocks apart, correct values. Repeat with UART_RX_MAJORITY_EN and a 1-clock inverted glitch at each bit centre → same results.
